// File: rtl/apb_global_pkg.sv
// rtl/apb_global_pkg.sv - shared APB types, default sizing and arbiter request record
package apb_global_pkg;

    parameter int NO_OF_REQUESTERS  = 2;
    parameter int NO_OF_SLAVES      = 1;
    parameter int ADDRESS_WIDTH     = 32;
    parameter int DATA_WIDTH        = 32;
    parameter int SLAVE_MEMORY_SIZE = 12;
    parameter int SLAVE_MEMORY_GAP  = 5;

    // Distance in bytes between consecutive slave windows (window plus unmapped gap).
    function automatic int slave_stride(input int size_kb, input int gap_bytes);
        return size_kb * 1024 + gap_bytes;
    endfunction

    localparam int SLAVE_STRIDE = slave_stride(SLAVE_MEMORY_SIZE, SLAVE_MEMORY_GAP);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        SETUP      = 2'b01,
        ACCESS     = 2'b10,
        WAIT_STATE = 2'b11
    } apb_fsm_state_e;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } tx_type_e;

    typedef enum logic [2:0] {
        NORMAL_SECURE_DATA              = 3'b000,
        PRIVILEGED_SECURE_DATA          = 3'b001,
        NORMAL_NONSECURE_DATA           = 3'b010,
        PRIVILEGED_NONSECURE_DATA       = 3'b011,
        NORMAL_SECURE_INSTRUCTION       = 3'b100,
        PRIVILEGED_SECURE_INSTRUCTION   = 3'b101,
        NORMAL_NONSECURE_INSTRUCTION    = 3'b110,
        PRIVILEGED_NONSECURE_INSTRUCTION = 3'b111
    } protection_type_e;

    typedef enum logic {
        NO_ERROR = 1'b0,
        ERROR    = 1'b1
    } slave_error_e;

    // Request fields captured from the winning requester on the grant edge.
    typedef struct packed {
        tx_type_e                    pwrite;
        logic [ADDRESS_WIDTH-1:0]    paddr;
        logic [DATA_WIDTH-1:0]       pwdata;
        logic [DATA_WIDTH/8-1:0]     pstrb;
        protection_type_e            pprot;
    } apb_arb_req_s;

endpackage

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - round-robin requester arbiter with its own rotating pointer
module apb_rr_arbiter #(
    parameter int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_q;
    logic          found;
    int            idx;

    // Scan from the pointer and pick the first active request, wrapping around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr_q) + off) % N;
            if (enable && !found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IW'(idx);
            end
        end
    end

    // Pointer moves to the requester just after the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - shared APB master: RR arbitration, decode, APB phases (optional APB_TIMEOUT_EN)
module apb_master_arbiter #(
    parameter int NO_OF_REQUESTERS  = apb_global_pkg::NO_OF_REQUESTERS,
    parameter int NO_OF_SLAVES      = apb_global_pkg::NO_OF_SLAVES,
    parameter int ADDRESS_WIDTH     = apb_global_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH        = apb_global_pkg::DATA_WIDTH,
    parameter int SLAVE_MEMORY_SIZE = apb_global_pkg::SLAVE_MEMORY_SIZE,
    parameter int SLAVE_MEMORY_GAP  = apb_global_pkg::SLAVE_MEMORY_GAP
`ifdef APB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES    = 16
`endif
) (
    input  logic                                   pclk,
    input  logic                                   preset_n,
    input  logic [NO_OF_REQUESTERS-1:0]            req_valid,
    output logic [NO_OF_REQUESTERS-1:0]            req_ready,
    input  logic [NO_OF_REQUESTERS-1:0]            req_pwrite,
    input  logic [NO_OF_REQUESTERS*ADDRESS_WIDTH-1:0] req_paddr,
    input  logic [NO_OF_REQUESTERS*DATA_WIDTH-1:0] req_pwdata,
    input  logic [NO_OF_REQUESTERS*DATA_WIDTH/8-1:0] req_pstrb,
    input  logic [NO_OF_REQUESTERS*3-1:0]          req_pprot,
    output logic [NO_OF_REQUESTERS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]                  rsp_prdata,
    output logic                                   rsp_pslverr,
    output logic [NO_OF_SLAVES-1:0]                psel,
    output logic                                   penable,
    output logic                                   pwrite,
    output logic [ADDRESS_WIDTH-1:0]               paddr,
    output logic [DATA_WIDTH-1:0]                  pwdata,
    output logic [DATA_WIDTH/8-1:0]                pstrb,
    output logic [2:0]                             pprot,
    input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0]     prdata,
    input  logic [NO_OF_SLAVES-1:0]                pready,
    input  logic [NO_OF_SLAVES-1:0]                pslverr
);

    import apb_global_pkg::*;

    localparam int IW     = (NO_OF_REQUESTERS > 1) ? $clog2(NO_OF_REQUESTERS) : 1;
    localparam int SW     = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
    localparam int STRIDE = slave_stride(SLAVE_MEMORY_SIZE, SLAVE_MEMORY_GAP);
    localparam int WINDOW = SLAVE_MEMORY_SIZE * 1024;

    apb_fsm_state_e              state_q, state_d;
    apb_arb_req_s                req_q, gnt_req;
    logic [SW-1:0]               slave_q, gnt_slave;
    logic [IW-1:0]               owner_q, gnt_idx;
    logic [NO_OF_REQUESTERS-1:0] gnt;
    logic                        gnt_any, gnt_mapped, latch_en, arb_enable;
    logic [32:0]                 addr_ext, win_base, win_last;
    logic                        sel_pready, sel_pslverr;
    logic [DATA_WIDTH-1:0]       sel_prdata;
    logic [NO_OF_REQUESTERS-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]       rsp_prdata_q, rsp_prdata_d;
    logic                        rsp_pslverr_q, rsp_pslverr_d;
`ifdef APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]               to_cnt_q;
    logic                        to_expired;
`endif

    // Grants are only offered while the bus is idle and out of reset.
    assign arb_enable = (state_q == IDLE) && preset_n;

    apb_rr_arbiter #(.N(NO_OF_REQUESTERS)) u_rr_arbiter (
        .clk       (pclk),
        .rst_n     (preset_n),
        .req       (req_valid),
        .enable    (arb_enable),
        .grant     (gnt),
        .grant_idx (gnt_idx)
    );

    assign gnt_any   = |gnt;
    assign req_ready = gnt;

    // Select the winning requester's fields from the packed request buses.
    always_comb begin
        gnt_req        = '0;
        gnt_req.pwrite = tx_type_e'(req_pwrite[gnt_idx]);
        gnt_req.paddr  = req_paddr[int'(gnt_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        gnt_req.pwdata = req_pwdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        gnt_req.pstrb  = req_pstrb[int'(gnt_idx)*(DATA_WIDTH/8) +: DATA_WIDTH/8];
        gnt_req.pprot  = protection_type_e'(req_pprot[int'(gnt_idx)*3 +: 3]);
    end

    // Window decode in 33 bits so the last window bound can never wrap.
    always_comb begin
        addr_ext   = 33'(gnt_req.paddr);
        gnt_mapped = 1'b0;
        gnt_slave  = '0;
        win_base   = '0;
        win_last   = '0;
        for (int k = 0; k < NO_OF_SLAVES; k++) begin
            win_base = 33'(k * STRIDE);
            win_last = win_base + 33'(WINDOW - 1);
            if (addr_ext >= win_base && addr_ext <= win_last) begin
                gnt_mapped = 1'b1;
                gnt_slave  = SW'(k);
            end
        end
    end

    assign sel_pready  = pready[slave_q];
    assign sel_pslverr = pslverr[slave_q];
    assign sel_prdata  = prdata[int'(slave_q)*DATA_WIDTH +: DATA_WIDTH];

`ifdef APB_TIMEOUT_EN
    assign to_expired = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Count stalled cycles of the current transfer; restart on every SETUP entry.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            to_cnt_q <= '0;
        end else if (state_d == SETUP) begin
            to_cnt_q <= '0;
        end else if ((state_q == ACCESS || state_q == WAIT_STATE) && !sel_pready) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`endif

    // APB phase sequencing and completion response generation.
    always_comb begin
        state_d       = state_q;
        latch_en      = 1'b0;
        rsp_valid_d   = '0;
        rsp_prdata_d  = '0;
        rsp_pslverr_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    if (gnt_mapped) begin
                        latch_en = 1'b1;
                        state_d  = SETUP;
                    end else begin
                        rsp_valid_d   = gnt;
                        rsp_pslverr_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS, WAIT_STATE: begin
                if (sel_pready) begin
                    state_d       = IDLE;
                    rsp_valid_d   = NO_OF_REQUESTERS'(1) << owner_q;
                    rsp_prdata_d  = (req_q.pwrite == WRITE) ? '0 : sel_prdata;
                    rsp_pslverr_d = sel_pslverr;
                end else begin
                    state_d = WAIT_STATE;
`ifdef APB_TIMEOUT_EN
                    if (to_expired) begin
                        state_d       = IDLE;
                        rsp_valid_d   = NO_OF_REQUESTERS'(1) << owner_q;
                        rsp_pslverr_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch and registered response.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            req_q         <= '0;
            slave_q       <= '0;
            owner_q       <= '0;
            rsp_valid_q   <= '0;
            rsp_prdata_q  <= '0;
            rsp_pslverr_q <= 1'b0;
        end else begin
            if (latch_en) begin
                req_q   <= gnt_req;
                slave_q <= gnt_slave;
                owner_q <= gnt_idx;
            end
            rsp_valid_q   <= rsp_valid_d;
            rsp_prdata_q  <= rsp_prdata_d;
            rsp_pslverr_q <= rsp_pslverr_d;
        end
    end

    assign psel        = (state_q == IDLE) ? '0 : (NO_OF_SLAVES'(1) << slave_q);
    assign penable     = (state_q == ACCESS) || (state_q == WAIT_STATE);
    assign pwrite      = req_q.pwrite;
    assign paddr       = req_q.paddr;
    assign pwdata      = req_q.pwdata;
    assign pstrb       = req_q.pstrb;
    assign pprot       = req_q.pprot;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_prdata  = rsp_prdata_q;
    assign rsp_pslverr = rsp_pslverr_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - scoreboard bench for apb_master_arbiter
module tb_apb_master_arbiter;

    localparam int NR     = 2;
    localparam int NS     = 2;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SBW    = DW / 8;
    localparam int WIN    = 12 * 1024;
    localparam int STRIDE = WIN + 5;

    logic              pclk = 1'b0;
    logic              preset_n = 1'b0;
    logic [NR-1:0]     req_valid = '0, req_ready, req_pwrite = '0, rsp_valid;
    logic [NR*AW-1:0]  req_paddr = '0;
    logic [NR*DW-1:0]  req_pwdata = '0;
    logic [NR*SBW-1:0] req_pstrb = '0;
    logic [NR*3-1:0]   req_pprot = '0;
    logic [DW-1:0]     rsp_prdata;
    logic              rsp_pslverr;
    logic [NS-1:0]     psel;
    logic              penable, pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [SBW-1:0]    pstrb;
    logic [2:0]        pprot;
    logic [NS*DW-1:0]  prdata;
    logic [NS-1:0]     pready, pslverr;

    int                errors = 0;
    int                checks = 0;

    always #5 pclk = ~pclk;

    apb_master_arbiter #(
        .NO_OF_REQUESTERS (NR),
        .NO_OF_SLAVES     (NS)
    ) dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_pwrite  (req_pwrite),
        .req_paddr   (req_paddr),
        .req_pwdata  (req_pwdata),
        .req_pstrb   (req_pstrb),
        .req_pprot   (req_pprot),
        .rsp_valid   (rsp_valid),
        .rsp_prdata  (rsp_prdata),
        .rsp_pslverr (rsp_pslverr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pprot       (pprot),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    // Slave model: inserts wait_states low-pready cycles at the start of ACCESS.
    int            wait_states = 0;
    int            ws_cnt = 0;
    logic [DW-1:0] rd0 = '0, rd1 = '0;
    logic          serr0 = 1'b0, serr1 = 1'b0;

    always @(posedge pclk or negedge preset_n) begin
        if (!preset_n) ws_cnt <= 0;
        else if (psel != 0 && penable) ws_cnt <= ws_cnt + 1;
        else ws_cnt <= 0;
    end
    assign pready  = (ws_cnt >= wait_states) ? {NS{1'b1}} : {NS{1'b0}};
    assign prdata  = {rd1, rd0};
    assign pslverr = {serr1, serr0};

    // Reference decode: division-based window lookup, -1 when unmapped.
    function automatic int slave_of(input logic [AW-1:0] a);
        longint la;
        la = longint'(a);
        if ((la / STRIDE) < NS && (la % STRIDE) < WIN) return int'(la / STRIDE);
        return -1;
    endfunction

    typedef struct {
        int            r;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t sb[$];
    logic expect_timeout = 1'b0;

    // Scoreboard: pop and compare on each response, push a prediction on each grant.
    always @(negedge pclk) begin
        exp_t          e;
        logic [NR-1:0] ev;
        int            k;
        if (preset_n && rsp_valid != 0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: rsp_valid=%b, no transfer outstanding", rsp_valid);
            end else begin
                e = sb.pop_front();
                ev = '0;
                ev[e.r] = 1'b1;
                if (rsp_valid !== ev) begin
                    errors++;
                    $display("FAIL rsp_owner: rsp_valid=%b expected %b", rsp_valid, ev);
                end
                checks++;
                if (rsp_prdata !== e.data) begin
                    errors++;
                    $display("FAIL rsp_prdata: got %h expected %h", rsp_prdata, e.data);
                end
                checks++;
                if (rsp_pslverr !== e.err) begin
                    errors++;
                    $display("FAIL rsp_pslverr: got %b expected %b", rsp_pslverr, e.err);
                end
            end
        end
        if (preset_n && req_ready != 0) begin
            for (int r = 0; r < NR; r++) begin
                if (req_ready[r]) begin
                    k = slave_of(req_paddr[r*AW +: AW]);
                    e.r = r;
                    if (k < 0) begin
                        e.data = '0;
                        e.err  = 1'b1;
                    end else if (expect_timeout) begin
                        e.data = '0;
                        e.err  = 1'b1;
                    end else begin
                        e.data = req_pwrite[r] ? '0 : (k == 0 ? rd0 : rd1);
                        e.err  = (k == 0) ? serr0 : serr1;
                    end
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic drive_req(input int r, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [SBW-1:0] s, input logic [2:0] p);
        req_pwrite[r]          = w;
        req_paddr[r*AW +: AW]  = a;
        req_pwdata[r*DW +: DW] = d;
        req_pstrb[r*SBW +: SBW] = s;
        req_pprot[r*3 +: 3]    = p;
        req_valid[r]           = 1'b1;
    endtask

    task automatic wait_grant(input int r, output bit ok);
        int c;
        c = 0;
        do begin
            @(negedge pclk);
            c++;
        end while (req_ready[r] !== 1'b1 && c < 20);
        ok = (req_ready[r] === 1'b1);
        @(posedge pclk); #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_access(output bit ok);
        int c;
        c = 0;
        do begin
            @(negedge pclk);
            c++;
        end while (penable !== 1'b1 && c < 20);
        ok = (penable === 1'b1);
    endtask

    task automatic do_reset();
        preset_n = 1'b0;
        repeat (2) @(posedge pclk);
        #1 preset_n = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = 2'b01;
        @(negedge pclk);
        checks++;
        if ({psel, penable, req_ready, rsp_valid, pwrite} !== '0 || paddr !== '0 || pwdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: psel=%b penable=%b req_ready=%b rsp_valid=%b paddr=%h expected all 0",
                     psel, penable, req_ready, rsp_valid, paddr);
        end
        req_valid = '0;
        @(posedge pclk); #1 preset_n = 1'b1;
        @(negedge pclk);
        checks++;
        if ({psel, penable, req_ready, rsp_valid} !== '0) begin
            errors++;
            $display("FAIL reset_release: psel=%b penable=%b req_ready=%b rsp_valid=%b expected 0",
                     psel, penable, req_ready, rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        int            got[$];
        int            exp_order[4];
        int            last, setups;
        logic [AW-1:0] a;
        logic          w;
        exp_order = '{0, 1, 0, 1};
        last = -1;
        setups = 0;
        rd0 = 32'h0BAD_0200;
        @(posedge pclk); #1;
        drive_req(0, 1'b1, 32'h0000_0100, 32'h1111_2222, 4'hF, 3'b001);
        drive_req(1, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 3'b000);
        for (int c = 0; c < 40 && setups < 4; c++) begin
            @(negedge pclk);
            if (psel != 0 && !penable && last >= 0) begin
                setups++;
                a = (last == 0) ? 32'h0000_0100 : 32'h0000_0200;
                w = (last == 0);
                checks++;
                if (paddr !== a || pwrite !== w) begin
                    errors++;
                    $display("FAIL rr_bus_fields: paddr=%h pwrite=%b expected %h %b", paddr, pwrite, a, w);
                end
            end
            if (req_ready != 0) begin
                last = req_ready[1] ? 1 : 0;
                got.push_back(last);
                if (got.size() == 4) begin
                    @(posedge pclk); #1;
                    req_valid = '0;
                end
            end
        end
        req_valid = '0;
        checks++;
        if (got.size() != 4 || setups != 4) begin
            errors++;
            $display("FAIL rr_count: grants=%0d setups=%0d expected 4 4", got.size(), setups);
        end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++;
            if (got[i] != exp_order[i]) begin
                errors++;
                $display("FAIL rr_order: grant %0d went to R%0d expected R%0d", i, got[i], exp_order[i]);
            end
        end
        repeat (5) @(negedge pclk);
    endtask

    task automatic test_single_read();
        rd0 = 32'hA5A5_0001;
        wait_states = 0;
        @(posedge pclk); #1;
        drive_req(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 3'b000);
        @(negedge pclk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_grant: req_ready=%b expected 01", req_ready);
        end
        @(posedge pclk); #1 req_valid = '0;
        @(negedge pclk);
        checks++;
        if (psel !== 2'b01 || penable !== 1'b0 || paddr !== 32'h10 || pwrite !== 1'b0) begin
            errors++;
            $display("FAIL single_setup: psel=%b penable=%b paddr=%h pwrite=%b expected 01 0 00000010 0",
                     psel, penable, paddr, pwrite);
        end
        @(negedge pclk);
        checks++;
        if (psel !== 2'b01 || penable !== 1'b1) begin
            errors++;
            $display("FAIL single_access: psel=%b penable=%b expected 01 1", psel, penable);
        end
        @(negedge pclk);
        checks++;
        if (rsp_valid !== 2'b01 || psel !== 2'b00) begin
            errors++;
            $display("FAIL single_rsp_time: rsp_valid=%b psel=%b expected 01 00", rsp_valid, psel);
        end
        @(negedge pclk);
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL single_rsp_pulse: rsp_valid=%b expected 00", rsp_valid);
        end
    endtask

    task automatic test_wait_states();
        bit ok;
        int k;
        rd0 = 32'h7777_8888;
        wait_states = 3;
        @(posedge pclk); #1;
        drive_req(1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0101, 3'b010);
        wait_grant(1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ws_grant: req_ready=%b expected bit 1 set", req_ready);
        end
        wait_access(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ws_access: penable=%b expected 1", penable);
        end
        k = 0;
        while (k < 12) begin
            checks++;
            if (psel !== 2'b01 || penable !== 1'b1 || pwrite !== 1'b1 || paddr !== 32'h2000 ||
                pwdata !== 32'hDEAD_BEEF || pstrb !== 4'b0101 || pprot !== 3'b010) begin
                errors++;
                $display("FAIL ws_stable: cycle %0d psel=%b penable=%b paddr=%h pwdata=%h pstrb=%b pprot=%b",
                         k, psel, penable, paddr, pwdata, pstrb, pprot);
            end
            @(negedge pclk);
            k++;
            if (rsp_valid != 0) break;
        end
        checks++;
        if (k != 4) begin
            errors++;
            $display("FAIL ws_latency: rsp_valid %0d cycles after ACCESS entry, expected 4", k);
        end
        wait_states = 0;
        repeat (2) @(negedge pclk);
    endtask

    task automatic test_decode();
        logic [AW-1:0] addrs[7];
        logic [NS-1:0] exp_sel[7];
        logic          errs[7];
        bit            ok;
        addrs   = '{WIN + 2, WIN + 5, WIN - 1, 2 * STRIDE, STRIDE + WIN - 1, STRIDE + WIN, 32'hFFFF_FFFF};
        exp_sel = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
        errs    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rd0 = 32'h1234_5678;
        rd1 = 32'h5151_0002;
        for (int i = 0; i < 7; i++) begin
            serr1 = errs[i];
            @(posedge pclk); #1;
            drive_req(0, 1'b0, addrs[i], 32'h0, 4'hF, 3'b000);
            wait_grant(0, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL dec_grant: addr=%h req_ready=%b", addrs[i], req_ready);
            end
            @(negedge pclk);
            checks++;
            if (psel !== exp_sel[i] || penable !== 1'b0) begin
                errors++;
                $display("FAIL dec_psel: addr=%h psel=%b penable=%b expected %b 0",
                         addrs[i], psel, penable, exp_sel[i]);
            end
            if (exp_sel[i] == 0) begin
                checks++;
                if (rsp_valid !== 2'b01) begin
                    errors++;
                    $display("FAIL dec_unmapped_rsp: addr=%h rsp_valid=%b expected 01", addrs[i], rsp_valid);
                end
            end
            repeat (3) @(negedge pclk);
            serr1 = 1'b0;
        end
    endtask

    task automatic test_long_wait();
        bit ok;
        int k;
        wait_states = 1000;
`ifdef APB_TIMEOUT_EN
        expect_timeout = 1'b1;
`endif
        @(posedge pclk); #1;
        drive_req(0, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 3'b000);
        wait_grant(0, ok);
        wait_access(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL lw_access: penable=%b expected 1", penable);
        end
`ifdef APB_TIMEOUT_EN
        k = 0;
        while (k < 40 && rsp_valid == 0) begin
            @(negedge pclk);
            k++;
        end
        checks++;
        if (k != 16 || psel !== 2'b00 || penable !== 1'b0) begin
            errors++;
            $display("FAIL lw_timeout: abort after %0d cycles psel=%b penable=%b expected 16 00 0", k, psel, penable);
        end
        expect_timeout = 1'b0;
        wait_states = 0;
        repeat (2) @(negedge pclk);
`else
        for (int c = 0; c < 30; c++) begin
            @(negedge pclk);
            checks++;
            if (psel !== 2'b01 || penable !== 1'b1 || rsp_valid !== 2'b00) begin
                errors++;
                $display("FAIL lw_hold: cycle %0d psel=%b penable=%b rsp_valid=%b expected 01 1 00",
                         c, psel, penable, rsp_valid);
            end
        end
        do_reset();
        sb.delete();
        wait_states = 0;
        @(negedge pclk);
`endif
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        wait_states = 8;
        @(posedge pclk); #1;
        drive_req(0, 1'b0, 32'h0000_0080, 32'h0, 4'hF, 3'b000);
        wait_grant(0, ok);
        wait_access(ok);
        repeat (3) @(negedge pclk);
        checks++;
        if (penable !== 1'b1 || psel !== 2'b01) begin
            errors++;
            $display("FAIL rw_in_wait: psel=%b penable=%b expected 01 1", psel, penable);
        end
        #2 preset_n = 1'b0;
        #1;
        checks++;
        if (psel !== 2'b00 || penable !== 1'b0 || rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL rw_async: psel=%b penable=%b rsp_valid=%b expected 00 0 00", psel, penable, rsp_valid);
        end
        sb.delete();
        @(posedge pclk); #1 preset_n = 1'b1;
        wait_states = 0;
        rd0 = 32'hCAFE_0300;
        @(posedge pclk); #1;
        drive_req(0, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 3'b000);
        drive_req(1, 1'b0, 32'h0000_0304, 32'h0, 4'hF, 3'b000);
        @(negedge pclk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rw_ptr_reset: req_ready=%b expected 01", req_ready);
        end
        @(posedge pclk); #1 req_valid = '0;
        repeat (5) @(negedge pclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge pclk);
        test_reset();
        test_round_robin();
        test_single_read();
        test_wait_states();
        test_decode();
        test_long_wait();
        test_reset_in_wait();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d responses outstanding, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
